sat_frame_ctrl: RTL and testbench
=================================

# sat_frame_ctrl

Per-frame sequencer for the saturation-estimation datapath. Sits between the pixel source and the `calc_sat` stage. Keeps the atmospheric light A stable for a whole frame and primes the inverse-A LUT before the first pixel. Gates pixels into the datapath and drains the 8-cycle pipeline before it accepts a new A value or the next frame.

## Interface
Parameters:
- `PIPE_LAT`, 8, cycles from datapath `in_valid` to `out_valid`
- `LUT_LAT`, 1, cycles from an A change to a valid inverse-A LUT output
- `DIM_W`, 11, width of the frame dimension fields

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_width`, `cfg_height`  in  DIM_W each  frame size in pixels, sampled on the IDLE→PRIME transition
- `s_valid`  in  1  source pixel valid
- `s_ready`  out  1  controller accepts the pixel
- `s_sof`  in  1  start of frame, qualified by `s_valid`
- `s_r`, `s_g`, `s_b`  in  8 each  source pixel
- `a_new_valid`  in  1  one-cycle strobe: new A estimate
- `a_new_r`, `a_new_g`, `a_new_b`  in  8 each  new A estimate
- `m_valid`  out  1  drives datapath `in_valid`
- `m_r`, `m_g`, `m_b`  out  8 each  drives datapath `in_r/g/b`
- `A_r`, `A_g`, `A_b`  out  8 each  drives datapath A inputs
- `A_valid`  out  1  drives datapath `A_valid`
- `dp_out_valid`  in  1  datapath `out_valid`
- `busy`  out  1  high in any state other than IDLE
- `frame_done`  out  1  one-cycle pulse when a frame has fully drained

## Operation
- Reset values:
  - Controller: state IDLE.
  - Outputs: `s_ready=0`, `m_valid=0`, `m_r/g/b=0`, `A_r/g/b=8'hFF`, `A_valid=0`, `busy=0`, `frame_done=0`.
  - Internal: pending flag 0, all counters 0.
- Pending A:
  - `a_new_valid` writes the pending register and sets the pending flag in any state.
  - If several strobes arrive, the last one wins.
  - Pending A is copied to `A_*` only on the IDLE→PRIME transition.
- States:
  - IDLE
    - `s_ready=0`.
    - Leaves when all of these hold: `s_valid & s_sof`, (`A_valid` or pending flag), `cfg_width!=0`, `cfg_height!=0`.
    - On leaving: latch total = `cfg_width*cfg_height` (2·DIM_W bits).
    - On leaving, if the pending flag is set: load `A_*`, set `A_valid=1`, clear the pending flag.
    - Goes to PRIME.
    - `s_valid` without `s_sof` in IDLE is dropped: `s_ready` is pulsed 1 for that cycle to discard the beat.
  - PRIME
    - Lasts exactly `LUT_LAT+1` cycles with `s_ready=0`, then goes to RUN.
  - RUN
    - `s_ready=1`.
    - On each beat (`s_valid & s_ready`): register `s_*` into `m_*`, set `m_valid=1` on the next cycle, increment the input count.
    - When the beat that brings the input count to total is accepted, the next state is DRAIN, and `s_ready` is 0 from the following cycle.
    - `s_sof` on a non-first beat is passed through as data; no restart.
  - DRAIN
    - `s_ready=0`.
    - Counts `dp_out_valid` pulses, counting continuously from the first RUN beat.
    - When the output count equals total, `frame_done` pulses for 1 cycle and the state returns to IDLE.
    - All counters clear on entry to IDLE.
- `m_valid` is 0 in every cycle without an accepted beat; `m_*` data holds its last value.
- `A_*` never changes while in PRIME, RUN or DRAIN.
- `rst` mid-frame returns to the reset values immediately; any in-flight datapath results are ignored.

## Timing
- Beat accepted in cycle t → `m_valid` in t+1 → `dp_out_valid` in t+1+`PIPE_LAT`.
- SOF seen in IDLE in cycle t → PRIME occupies t+1..t+1+`LUT_LAT` → first `s_ready=1` in t+2+`LUT_LAT`.
- With defaults and a continuous source: last beat in cycle L → `frame_done` in L+10.
  - Counted as: `m_valid` at L+1, `dp_out_valid` at L+9, output count registered in DRAIN, pulse at L+10.
- `a_new_valid` arriving in the same cycle as IDLE→PRIME: the new value is used for that frame; pending bypasses directly to `A_*`.
- Back-to-back frames: minimum gap from `frame_done` to the next `s_ready` is `LUT_LAT+2` cycles.

## Configuration
- `SAT_CTRL_CHECK_EN` defined:
  - Adds output `err` (1 bit, reset 0, sticky until `rst`).
  - `err` sets on `dp_out_valid` in IDLE or PRIME.
  - `err` sets if the output count would exceed total.
  - `err` sets on `s_sof` on a non-first RUN beat.
- Not defined: the `err` port and its logic are absent; those conditions are silently ignored.

## Test plan
- Reset, `cfg` 4×2, A strobe (200,180,160), one SOF frame of 8 continuous beats → `A_*`=(200,180,160) and `A_valid`=1 before the first beat; 8 `m_valid` pulses; `frame_done` exactly 10 cycles after the last beat.
- No A ever supplied, `s_valid&s_sof` held → stays IDLE; `s_ready`=0; `busy`=0.
- `a_new_valid` (50,50,50) in mid-RUN → `A_*` unchanged until the next frame's PRIME; next frame uses 50.
- Source with `s_valid` toggling every other cycle, `cfg` 3×3 → 9 `m_valid` pulses, each 1 cycle after its beat; `frame_done` after the 9th `dp_out_valid`.
- `cfg_width=0` with SOF → no transition; `cfg_width=2`, `cfg_height=1` with non-SOF beats first → those are discarded until SOF, then 2 beats accepted.
- `rst` asserted mid-DRAIN → all outputs at reset values next cycle; with `SAT_CTRL_CHECK_EN`, an injected extra `dp_out_valid` in IDLE → `err`=1 and held.

Source files
------------

// File: rtl/sat_frame_ctrl.sv
// ============================================================================
// sat_frame_ctrl
// ----------------------------------------------------------------------------
// Per-frame sequencer in front of the calc_sat saturation datapath.
//
// Purpose:
//   - Holds the atmospheric light A constant for a whole frame. A new A
//     estimate may arrive at any time; it is parked in a pending register
//     and only applied when the next frame starts.
//   - Gives the inverse-A LUT LUT_LAT+1 cycles to settle (PRIME) before the
//     first pixel of a frame is let through.
//   - Gates source pixels into the datapath (RUN), then waits for every
//     pixel to come back out of the PIPE_LAT-deep pipeline (DRAIN) before
//     it will start another frame or apply a new A.
//
// Parameters:
//   PIPE_LAT  cycles from datapath in_valid to out_valid (default 8)
//   LUT_LAT   cycles from an A change to a valid inverse-A LUT output (default 1)
//   DIM_W     width of the frame dimension fields (default 11)
//
// Ports:
//   clk, rst                 single rising-edge clock, synchronous active-high reset
//   cfg_width, cfg_height    frame size, sampled when a frame starts
//   s_valid/s_ready/s_sof    source pixel handshake and start-of-frame flag
//   s_r, s_g, s_b            source pixel
//   a_new_valid, a_new_*     one-cycle strobe carrying a new A estimate
//   m_valid, m_r/g/b         pixel stream into the datapath
//   A_r/g/b, A_valid         A value presented to the datapath
//   dp_out_valid             datapath result strobe
//   busy                     high whenever the controller is not idle
//   frame_done               one-cycle pulse when a frame has fully drained
//   err                      (only with SAT_CTRL_CHECK_EN) sticky protocol error
//
// Configuration:
//   SAT_CTRL_CHECK_EN  when defined, adds the sticky 'err' output flagging
//                      stray datapath results, output overcount and an SOF
//                      appearing inside a frame. Undefined by default; those
//                      conditions are then silently ignored.
// ============================================================================
module sat_frame_ctrl #(
    parameter int PIPE_LAT = 8,
    parameter int LUT_LAT  = 1,
    parameter int DIM_W    = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_sof,
    input  logic [7:0]       s_r,
    input  logic [7:0]       s_g,
    input  logic [7:0]       s_b,
    input  logic             a_new_valid,
    input  logic [7:0]       a_new_r,
    input  logic [7:0]       a_new_g,
    input  logic [7:0]       a_new_b,
    output logic             m_valid,
    output logic [7:0]       m_r,
    output logic [7:0]       m_g,
    output logic [7:0]       m_b,
    output logic [7:0]       A_r,
    output logic [7:0]       A_g,
    output logic [7:0]       A_b,
    output logic             A_valid,
    input  logic             dp_out_valid,
    output logic             busy,
    output logic             frame_done
`ifdef SAT_CTRL_CHECK_EN
    ,
    output logic             err
`endif
);

    // Pixel counters must hold width*height without overflow.
    localparam int TOT_W   = 2 * DIM_W;
    // Prime counter counts 0..LUT_LAT; sized so LUT_LAT=0 still gets one bit.
    localparam int PRIME_W = $clog2(LUT_LAT + 2);

    localparam logic [TOT_W-1:0]   TOT_ONE   = TOT_W'(1);
    localparam logic [PRIME_W-1:0] PRIME_ONE = PRIME_W'(1);
    localparam logic [PRIME_W-1:0] PRIME_END = PRIME_W'(LUT_LAT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic [TOT_W-1:0]   in_cnt_q, in_cnt_d;
    logic [TOT_W-1:0]   out_cnt_q, out_cnt_d;

    logic               pend_flag_q, pend_flag_d;
    logic [7:0]         pend_r_q, pend_r_d;
    logic [7:0]         pend_g_q, pend_g_d;
    logic [7:0]         pend_b_q, pend_b_d;

    logic [7:0]         a_r_q, a_r_d;
    logic [7:0]         a_g_q, a_g_d;
    logic [7:0]         a_b_q, a_b_d;
    logic               a_valid_q, a_valid_d;

    logic               m_valid_q, m_valid_d;
    logic [7:0]         m_r_q, m_r_d;
    logic [7:0]         m_g_q, m_g_d;
    logic [7:0]         m_b_q, m_b_d;

    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;

`ifdef SAT_CTRL_CHECK_EN
    logic               err_q, err_d;
`endif

    logic               beat;
    logic               start_ok;
    logic [TOT_W-1:0]   out_cnt_next;

    // s_ready is combinational on the registered state so a beat is taken in
    // the same cycle it is offered. In IDLE a non-SOF beat is acknowledged
    // only to throw it away, so the source can reach the next SOF.
    always_comb begin
        s_ready = 1'b0;
        if (!rst) begin
            if (state_q == ST_RUN) begin
                s_ready = 1'b1;
            end else if (state_q == ST_IDLE && s_valid && !s_sof) begin
                s_ready = 1'b1;
            end
        end
    end

    assign beat = s_valid && s_ready;

    // A frame may only start with an SOF beat, a usable A (already loaded or
    // pending) and a non-empty frame size.
    assign start_ok = (state_q == ST_IDLE) && s_valid && s_sof
                    && (a_valid_q || pend_flag_q)
                    && (cfg_width != '0) && (cfg_height != '0);

    // Output count including a result arriving this cycle.
    assign out_cnt_next = out_cnt_q + {{(TOT_W-1){1'b0}}, dp_out_valid};

    // Next-state and next-output logic for the whole controller. Every
    // register holds by default; m_valid and frame_done are single-cycle
    // strobes and default low.
    always_comb begin
        state_d      = state_q;
        prime_cnt_d  = prime_cnt_q;
        total_d      = total_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        pend_flag_d  = pend_flag_q;
        pend_r_d     = pend_r_q;
        pend_g_d     = pend_g_q;
        pend_b_d     = pend_b_q;
        a_r_d        = a_r_q;
        a_g_d        = a_g_q;
        a_b_d        = a_b_q;
        a_valid_d    = a_valid_q;
        m_valid_d    = 1'b0;
        m_r_d        = m_r_q;
        m_g_d        = m_g_q;
        m_b_d        = m_b_q;
        frame_done_d = 1'b0;

        // New A estimates are always captured; the latest strobe wins.
        if (a_new_valid) begin
            pend_flag_d = 1'b1;
            pend_r_d    = a_new_r;
            pend_g_d    = a_new_g;
            pend_b_d    = a_new_b;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d     = ST_PRIME;
                    prime_cnt_d = '0;
                    total_d     = TOT_W'(cfg_width) * TOT_W'(cfg_height);
                    // A strobe in this very cycle bypasses the pending
                    // register so the frame uses the newest estimate.
                    if (a_new_valid) begin
                        a_r_d       = a_new_r;
                        a_g_d       = a_new_g;
                        a_b_d       = a_new_b;
                        a_valid_d   = 1'b1;
                        pend_flag_d = 1'b0;
                    end else if (pend_flag_q) begin
                        a_r_d       = pend_r_q;
                        a_g_d       = pend_g_q;
                        a_b_d       = pend_b_q;
                        a_valid_d   = 1'b1;
                        pend_flag_d = 1'b0;
                    end
                end
            end

            ST_PRIME: begin
                // Hold the source off until the inverse-A LUT has settled.
                if (prime_cnt_q == PRIME_END) begin
                    state_d = ST_RUN;
                end else begin
                    prime_cnt_d = prime_cnt_q + PRIME_ONE;
                end
            end

            ST_RUN: begin
                if (beat) begin
                    m_valid_d = 1'b1;
                    m_r_d     = s_r;
                    m_g_d     = s_g;
                    m_b_d     = s_b;
                    in_cnt_d  = in_cnt_q + TOT_ONE;
                    if ((in_cnt_q + TOT_ONE) == total_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                // Results start returning while input is still flowing.
                out_cnt_d = out_cnt_next;
            end

            ST_DRAIN: begin
                out_cnt_d = out_cnt_next;
                if (out_cnt_next == total_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                    prime_cnt_d  = '0;
                    in_cnt_d     = '0;
                    out_cnt_d    = '0;
                    total_d      = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

`ifdef SAT_CTRL_CHECK_EN
    // Sticky protocol checker: a result with no frame in flight, more results
    // than pixels, or an SOF flag on a beat other than the first of a frame.
    always_comb begin
        err_d = err_q;
        if (dp_out_valid && (state_q == ST_IDLE || state_q == ST_PRIME)) begin
            err_d = 1'b1;
        end
        if (dp_out_valid && (state_q == ST_RUN || state_q == ST_DRAIN)
            && (out_cnt_q >= total_q)) begin
            err_d = 1'b1;
        end
        if (beat && (state_q == ST_RUN) && s_sof && (in_cnt_q != '0)) begin
            err_d = 1'b1;
        end
    end
`endif

    // Single register bank for the FSM, counters, pending A and all
    // registered outputs. Reset is synchronous; A resets to all-ones so the
    // datapath never sees a zero divisor.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prime_cnt_q  <= '0;
            total_q      <= '0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            pend_flag_q  <= 1'b0;
            pend_r_q     <= '0;
            pend_g_q     <= '0;
            pend_b_q     <= '0;
            a_r_q        <= 8'hFF;
            a_g_q        <= 8'hFF;
            a_b_q        <= 8'hFF;
            a_valid_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_r_q        <= '0;
            m_g_q        <= '0;
            m_b_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef SAT_CTRL_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prime_cnt_q  <= prime_cnt_d;
            total_q      <= total_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            pend_flag_q  <= pend_flag_d;
            pend_r_q     <= pend_r_d;
            pend_g_q     <= pend_g_d;
            pend_b_q     <= pend_b_d;
            a_r_q        <= a_r_d;
            a_g_q        <= a_g_d;
            a_b_q        <= a_b_d;
            a_valid_q    <= a_valid_d;
            m_valid_q    <= m_valid_d;
            m_r_q        <= m_r_d;
            m_g_q        <= m_g_d;
            m_b_q        <= m_b_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
`ifdef SAT_CTRL_CHECK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign m_valid    = m_valid_q;
    assign m_r        = m_r_q;
    assign m_g        = m_g_q;
    assign m_b        = m_b_q;
    assign A_r        = a_r_q;
    assign A_g        = a_g_q;
    assign A_b        = a_b_q;
    assign A_valid    = a_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
`ifdef SAT_CTRL_CHECK_EN
    assign err        = err_q;
`endif

endmodule

// File: tb/tb_sat_frame_ctrl.sv
// ============================================================================
// tb_sat_frame_ctrl
// ----------------------------------------------------------------------------
// Scoreboard bench for sat_frame_ctrl. The driver pushes the expected
// datapath beat (data, A, arrival cycle) for every pixel the controller
// accepts, plus the expected frame_done cycle for each frame; an independent
// monitor pops and compares whenever m_valid or frame_done is seen. A small
// shift-register model stands in for the PIPE_LAT-deep datapath.
// ============================================================================
`timescale 1ns/1ps
module tb_sat_frame_ctrl;

    localparam int PIPE_LAT = 8;
    localparam int LUT_LAT  = 1;
    localparam int DIM_W    = 11;

    logic             clk = 1'b0;
    logic             rst;
    logic [DIM_W-1:0] cfg_width;
    logic [DIM_W-1:0] cfg_height;
    logic             s_valid;
    logic             s_ready;
    logic             s_sof;
    logic [7:0]       s_r, s_g, s_b;
    logic             a_new_valid;
    logic [7:0]       a_new_r, a_new_g, a_new_b;
    logic             m_valid;
    logic [7:0]       m_r, m_g, m_b;
    logic [7:0]       A_r, A_g, A_b;
    logic             A_valid;
    logic             dp_out_valid;
    logic             busy;
    logic             frame_done;
`ifdef SAT_CTRL_CHECK_EN
    logic             err;
`endif

    logic                dpInject;
    logic [PIPE_LAT-1:0] dpPipe;
    int                  cyc = 0;
    int                  checkCount = 0;
    int                  failCount = 0;

    typedef struct {
        logic [7:0] r, g, b;
        logic [7:0] ar, ag, ab;
        int         cycle;
    } beat_t;

    beat_t mQ[$];
    int    fdQ[$];

    sat_frame_ctrl #(
        .PIPE_LAT (PIPE_LAT),
        .LUT_LAT  (LUT_LAT),
        .DIM_W    (DIM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_sof        (s_sof),
        .s_r          (s_r),
        .s_g          (s_g),
        .s_b          (s_b),
        .a_new_valid  (a_new_valid),
        .a_new_r      (a_new_r),
        .a_new_g      (a_new_g),
        .a_new_b      (a_new_b),
        .m_valid      (m_valid),
        .m_r          (m_r),
        .m_g          (m_g),
        .m_b          (m_b),
        .A_r          (A_r),
        .A_g          (A_g),
        .A_b          (A_b),
        .A_valid      (A_valid),
        .dp_out_valid (dp_out_valid),
        .busy         (busy),
        .frame_done   (frame_done)
`ifdef SAT_CTRL_CHECK_EN
        ,
        .err          (err)
`endif
    );

    // Free-running clock and cycle index used to time-stamp events.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Datapath stand-in: out_valid is in_valid delayed PIPE_LAT cycles,
    // with an extra injection input for stray results.
    always @(posedge clk) begin
        if (rst) begin
            dpPipe <= '0;
        end else begin
            dpPipe <= {dpPipe[PIPE_LAT-2:0], m_valid};
        end
    end

    assign dp_out_valid = dpPipe[PIPE_LAT-1] | dpInject;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output event.
    always @(negedge clk) begin : monitorBlk
        beat_t e;
        int    fdExp;
        if (m_valid) begin
            if (mQ.size() == 0) begin
                checkOutput("unexpectedMValid", 32'(m_valid), 32'd0);
            end else begin
                e = mQ.pop_front();
                checkOutput("mData", 32'({m_r, m_g, m_b}), 32'({e.r, e.g, e.b}));
                checkOutput("mCycle", 32'(cyc), 32'(e.cycle));
                checkOutput("aDuringBeat", 32'({A_r, A_g, A_b}), 32'({e.ar, e.ag, e.ab}));
                checkOutput("aValidDuringBeat", 32'(A_valid), 32'd1);
            end
        end
        if (frame_done) begin
            if (fdQ.size() == 0) begin
                checkOutput("unexpectedFrameDone", 32'(frame_done), 32'd0);
            end else begin
                fdExp = fdQ.pop_front();
                checkOutput("frameDoneCycle", 32'(cyc), 32'(fdExp));
            end
        end
    end

    // Offer one beat until accepted (bounded) and record the expected beat.
    // Entered and left #1 after a rising edge.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b, input logic sof,
                                 input logic [7:0] ar, input logic [7:0] ag,
                                 input logic [7:0] ab, output int acceptCyc);
        beat_t e;
        s_valid   = 1'b1;
        s_sof     = sof;
        s_r       = r;
        s_g       = g;
        s_b       = b;
        acceptCyc = -1;
        for (int w = 0; w < 40 && acceptCyc < 0; w++) begin
            @(negedge clk);
            if (s_ready) begin
                acceptCyc = cyc;
                e.r = r; e.g = g; e.b = b;
                e.ar = ar; e.ag = ag; e.ab = ab;
                e.cycle = cyc + 1;
                mQ.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;
        checkOutput("beatAccepted", 32'(acceptCyc >= 0), 32'd1);
    endtask

    // Send one frame starting from IDLE. 'gap' idle cycles follow each beat;
    // strobeIdx >= 0 fires a (50,50,50) A strobe alongside that beat.
    task automatic sendFrame(input int nBeats, input int gap,
                             input logic [7:0] ar, input logic [7:0] ag,
                             input logic [7:0] ab, input int strobeIdx);
        int         acc;
        int         startCyc;
        logic [7:0] r, g, b;
        startCyc = cyc;
        for (int k = 0; k < nBeats; k++) begin
            r = 8'(k * 17 + 3);
            g = 8'(250 - k * 5);
            b = 8'(k * 29 + 100);
            if (k == strobeIdx) begin
                a_new_valid = 1'b1;
                a_new_r     = 8'd50;
                a_new_g     = 8'd50;
                a_new_b     = 8'd50;
            end
            applyStimulus(r, g, b, (k == 0), ar, ag, ab, acc);
            a_new_valid = 1'b0;
            if (k == 0) begin
                checkOutput("firstBeatLatency", 32'(acc - startCyc), 32'(LUT_LAT + 2));
            end
            if (k == nBeats - 1) begin
                fdQ.push_back(acc + PIPE_LAT + 2);
            end
            for (int gi = 0; gi < gap; gi++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Wait (bounded) until the monitor has consumed the frame_done pulse.
    task automatic waitFrameDone();
        for (int w = 0; w < 60 && fdQ.size() != 0; w++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("frameDoneSeen", 32'(fdQ.size()), 32'd0);
        checkOutput("allBeatsSeen", 32'(mQ.size()), 32'd0);
        @(negedge clk);
        checkOutput("busyAfterDone", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Overall time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL globalTimeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] time limit reached");
    end

    // Directed scenario sequence.
    initial begin
        rst         = 1'b1;
        cfg_width   = '0;
        cfg_height  = '0;
        s_valid     = 1'b0;
        s_sof       = 1'b0;
        s_r         = '0;
        s_g         = '0;
        s_b         = '0;
        a_new_valid = 1'b0;
        a_new_r     = '0;
        a_new_g     = '0;
        a_new_b     = '0;
        dpInject    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values.
        @(negedge clk);
        checkOutput("rstSReady", 32'(s_ready), 32'd0);
        checkOutput("rstMValid", 32'(m_valid), 32'd0);
        checkOutput("rstMData", 32'({m_r, m_g, m_b}), 32'd0);
        checkOutput("rstA", 32'({A_r, A_g, A_b}), 32'h00FFFFFF);
        checkOutput("rstAValid", 32'(A_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;

        // No A ever supplied: SOF held, controller must stay idle.
        cfg_width  = 11'd4;
        cfg_height = 11'd2;
        s_valid    = 1'b1;
        s_sof      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("noASReady", 32'(s_ready), 32'd0);
            checkOutput("noABusy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_sof   = 1'b0;

        // Frame 1: A strobe (200,180,160), 4x2 continuous.
        a_new_valid = 1'b1;
        a_new_r     = 8'd200;
        a_new_g     = 8'd180;
        a_new_b     = 8'd160;
        @(posedge clk);
        #1;
        a_new_valid = 1'b0;
        sendFrame(8, 0, 8'd200, 8'd180, 8'd160, -1);
        waitFrameDone();
        checkOutput("aAfterFrame1", 32'({A_r, A_g, A_b}), 32'h00C8B4A0);

        // Frame 2: A strobe (50,50,50) mid-RUN must not disturb this frame.
        sendFrame(8, 0, 8'd200, 8'd180, 8'd160, 4);
        waitFrameDone();
        checkOutput("aHeldUntilPrime", 32'({A_r, A_g, A_b}), 32'h00C8B4A0);

        // Frame 3: 3x3 with s_valid toggling, uses the pending A of 50.
        cfg_width  = 11'd3;
        cfg_height = 11'd3;
        sendFrame(9, 1, 8'd50, 8'd50, 8'd50, -1);
        waitFrameDone();

        // Zero width with SOF: no transition.
        cfg_width  = 11'd0;
        cfg_height = 11'd2;
        s_valid    = 1'b1;
        s_sof      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("zeroWidthSReady", 32'(s_ready), 32'd0);
            checkOutput("zeroWidthBusy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end

        // 2x1 with non-SOF beats first: each is discarded in IDLE.
        cfg_width  = 11'd2;
        cfg_height = 11'd1;
        s_sof      = 1'b0;
        s_r        = 8'h11;
        s_g        = 8'h22;
        s_b        = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("discardSReady", 32'(s_ready), 32'd1);
            checkOutput("discardBusy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        sendFrame(2, 0, 8'd50, 8'd50, 8'd50, -1);
        waitFrameDone();

        // Reset in the middle of DRAIN.
        sendFrame(2, 0, 8'd50, 8'd50, 8'd50, -1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("drainBusy", 32'(busy), 32'd1);
        checkOutput("drainSReady", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        fdQ.delete();
        @(negedge clk);
        checkOutput("midRstSReady", 32'(s_ready), 32'd0);
        checkOutput("midRstMValid", 32'(m_valid), 32'd0);
        checkOutput("midRstMData", 32'({m_r, m_g, m_b}), 32'd0);
        checkOutput("midRstA", 32'({A_r, A_g, A_b}), 32'h00FFFFFF);
        checkOutput("midRstAValid", 32'(A_valid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstFrameDone", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef SAT_CTRL_CHECK_EN
        // Stray datapath result in IDLE raises a sticky error.
        @(negedge clk);
        checkOutput("errClear", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        dpInject = 1'b1;
        @(posedge clk);
        #1;
        dpInject = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("errSticky", 32'(err), 32'd1);
            @(posedge clk);
            #1;
        end
`endif

        repeat (15) @(posedge clk);
        #1;
        checkOutput("noLeftoverBeats", 32'(mQ.size()), 32'd0);
        checkOutput("busyAtEnd", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end

endmodule
